// File: rtl/quadrature_step_decoder.sv
// Quadrature A/B decoder: 2-FF synchronizers, prime/track FSM, step/dir strobes,
// wrapping position counter and sticky illegal-transition flag. Build option QDEC_FILTER_EN.
module quadrature_step_decoder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FILT  = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic             clear,
    output logic             step,
    output logic             dir,
    output logic [WIDTH-1:0] position,
    output logic             error
);

    typedef enum logic [0:0] {StPrime, StTrack} state_e;

    if (FILT < 2) begin : g_filt_chk
        $error("FILT must be >= 2");
    end

    state_e             state_q, state_d;
    logic [1:0]         meta_q, sync_q;
    logic [1:0]         prev_q, prev_d;
    logic [1:0]         prime_cnt_q, prime_cnt_d;
    logic               step_q, step_d;
    logic               dir_q, dir_d;
    logic [WIDTH-1:0]   pos_q, pos_d;
    logic               err_q, err_d;
    logic [1:0]         cur;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= 2'b00;
            sync_q <= 2'b00;
        end else begin
            meta_q <= {a, b};
            sync_q <= meta_q;
        end
    end

`ifdef QDEC_FILTER_EN
    localparam int unsigned CntW = $clog2(FILT);

    logic [1:0]           filt_q, filt_d;
    logic [1:0][CntW-1:0] run_q, run_d;

    // A phase's filtered level flips on the FILT-th consecutive differing sample;
    // filt_d is used combinationally so the filter adds only FILT-1 clocks.
    always_comb begin
        filt_d = filt_q;
        run_d  = run_q;
        for (int i = 0; i < 2; i++) begin
            if (sync_q[i] == filt_q[i]) begin
                run_d[i] = '0;
            end else if (run_q[i] == CntW'(FILT - 1)) begin
                filt_d[i] = sync_q[i];
                run_d[i]  = '0;
            end else begin
                run_d[i] = run_q[i] + 1'b1;
            end
        end
        if (state_q == StPrime) begin
            filt_d = sync_q;
            run_d  = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            filt_q <= 2'b00;
            run_q  <= '0;
        end else begin
            filt_q <= filt_d;
            run_q  <= run_d;
        end
    end

    assign cur = filt_d;
`else
    assign cur = sync_q;
`endif

    // PRIME lingers until the synchronizer holds post-reset pin levels, so a
    // static non-zero input is absorbed rather than decoded.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        prime_cnt_d = prime_cnt_q;
        step_d      = 1'b0;
        dir_d       = dir_q;
        pos_d       = pos_q;
        err_d       = err_q;
        if (clear) begin
            state_d     = StPrime;
            prime_cnt_d = 2'd0;
            pos_d       = '0;
            err_d       = 1'b0;
        end else begin
            unique case (state_q)
                StPrime: begin
                    prev_d = cur;
                    if (prime_cnt_q == 2'd2) begin
                        state_d     = StTrack;
                        prime_cnt_d = 2'd0;
                    end else begin
                        prime_cnt_d = prime_cnt_q + 2'd1;
                    end
                end
                StTrack: begin
                    prev_d = cur;
                    case ({prev_q, cur})
                        4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
                            step_d = 1'b1;
                            dir_d  = 1'b0;
                            pos_d  = pos_q + 1'b1;
                        end
                        4'b0100, 4'b1101, 4'b1011, 4'b0010: begin
                            step_d = 1'b1;
                            dir_d  = 1'b1;
                            pos_d  = pos_q - 1'b1;
                        end
                        4'b0011, 4'b1100, 4'b0110, 4'b1001: begin
                            err_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: state_d = StPrime;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StPrime;
            prev_q      <= 2'b00;
            prime_cnt_q <= 2'd0;
            step_q      <= 1'b0;
            dir_q       <= 1'b0;
            pos_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            prime_cnt_q <= prime_cnt_d;
            step_q      <= step_d;
            dir_q       <= dir_d;
            pos_q       <= pos_d;
            err_q       <= err_d;
        end
    end

    assign step     = step_q;
    assign dir      = dir_q;
    assign position = pos_q;
    assign error    = err_q;

endmodule
